pc_fetch_unit: RTL and testbench

- Program-counter and instruction-fetch stage for the 8-bit datapath.
- Sits directly downstream of the ALU: consumes the ALU `zero` flag to resolve conditional branches, and computes the next PC.
- Fetches the next instruction over a req/ack handshake with instruction memory.
- Includes a small return-address stack (RAS) for call/return.

---
 rtl/pc_fetch_unit_pkg.sv | 39 +++
 rtl/pc_fetch_unit_ras_stack.sv | 49 ++++
 rtl/pc_fetch_unit.sv | 119 +++++++++++
 tb/tb_pc_fetch_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// rtl/pc_fetch_unit_pkg.sv - shared types and constants for the fetch stage and control unit
package pc_fetch_unit_pkg;

  localparam int         PC_W_DEFAULT     = 8;
  localparam logic [7:0] RESET_PC_DEFAULT = 8'h00;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_EXEC  = 1'b1
  } state_t;

  // Command encoding in ascending priority; the control unit uses the same order.
  typedef enum logic [2:0] {
    CMD_NONE   = 3'd0,
    CMD_BRANCH = 3'd1,
    CMD_JUMP   = 3'd2,
    CMD_CALL   = 3'd3,
    CMD_RET    = 3'd4
  } cmd_t;

  // Pick the single winning command when several are raised together.
  function automatic cmd_t cmd_decode(input logic ret_en, input logic call_en,
                                      input logic jump_en, input logic br_en);
    if (ret_en)       return CMD_RET;
    else if (call_en) return CMD_CALL;
    else if (jump_en) return CMD_JUMP;
    else if (br_en)   return CMD_BRANCH;
    else              return CMD_NONE;
  endfunction

  // True when more than one command line is raised at once.
  function automatic logic cmd_conflict(input logic ret_en, input logic call_en,
                                        input logic jump_en, input logic br_en);
    logic [2:0] n;
    n = {2'b00, ret_en} + {2'b00, call_en} + {2'b00, jump_en} + {2'b00, br_en};
    return (n > 3'd1);
  endfunction

endpackage

// File: rtl/pc_fetch_unit_ras_stack.sv
// rtl/pc_fetch_unit_ras_stack.sv - circular return-address LIFO with overwrite-oldest on full
module pc_fetch_unit_ras_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic [PTR_W-1:0] top_idx;

  assign top_idx  = wr_ptr - PTR_W'(1);
  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = empty ? '0 : mem[top_idx];

  // Pointer and occupancy; when full the write pointer sits on the oldest entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (pop) begin
      if (!empty) begin
        wr_ptr <= top_idx;
        count  <= count - 1'b1;
      end
    end else if (push) begin
      wr_ptr <= wr_ptr + PTR_W'(1);
      if (!full) count <= count + 1'b1;
    end
  end

  // Entry storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push && !pop) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter, instruction fetch handshake and branch resolution
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int              PC_W      = PC_W_DEFAULT,
  parameter int              RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC  = PC_W'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  input  logic            imem_ack,
  input  logic [7:0]      imem_rdata,
  output logic [7:0]      instr,
  output logic            instr_valid,
  input  logic            exec_done,
  input  logic            br_en,
  input  logic            alu_zero,
  input  logic [7:0]      br_offset,
  input  logic            jump_en,
  input  logic            call_en,
  input  logic            ret_en,
  input  logic [PC_W-1:0] jump_target,
  output logic [PC_W-1:0] pc,
  output logic            ras_overflow,
  output logic            ras_underflow,
  output logic            cmd_error
);

  state_t          state_q, state_d;
  cmd_t            cmd;
  logic            fetch_fire, exec_fire;
  logic [PC_W-1:0] pc_q, pc_d, pc_plus1, off_ext, br_target;
  logic            ras_push, ras_pop, ras_full, ras_empty;
  logic [PC_W-1:0] ras_pop_data;

  // An ack only counts against an outstanding request, so a stray ack in EXEC is dropped.
  assign fetch_fire = (state_q == ST_FETCH) && imem_req && imem_ack;
  assign exec_fire  = (state_q == ST_EXEC) && exec_done;
  assign cmd        = cmd_decode(ret_en, call_en, jump_en, br_en);

  assign pc_plus1  = pc_q + PC_W'(1);
  assign off_ext   = PC_W'($signed(br_offset));
  assign br_target = pc_plus1 + off_ext;

  assign ras_push = exec_fire && (cmd == CMD_CALL);
  assign ras_pop  = exec_fire && (cmd == CMD_RET);

  pc_fetch_unit_ras_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (PC_W)
  ) u_ras_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_plus1),
    .pop_data  (ras_pop_data),
    .full      (ras_full),
    .empty     (ras_empty)
  );

  // Resolve the next PC from the winning command.
  always_comb begin
    pc_d = pc_plus1;
    unique case (cmd)
      CMD_RET:    pc_d = ras_empty ? pc_plus1 : ras_pop_data;
      CMD_CALL:   pc_d = jump_target;
      CMD_JUMP:   pc_d = jump_target;
      CMD_BRANCH: pc_d = alu_zero ? br_target : pc_plus1;
      default:    pc_d = pc_plus1;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_FETCH;
    else        state_q <= state_d;
  end

  // FSM next-state: fetch until acked, then hold until execution completes.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_FETCH: if (fetch_fire) state_d = ST_EXEC;
      ST_EXEC:  if (exec_done)  state_d = ST_FETCH;
      default:  state_d = ST_FETCH;
    endcase
  end

  // Datapath registers: request, captured instruction, pc and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_req      <= 1'b0;
      instr         <= 8'h00;
      instr_valid   <= 1'b0;
      pc_q          <= RESET_PC;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
      cmd_error     <= 1'b0;
    end else begin
      imem_req <= (state_d == ST_FETCH);
      if (fetch_fire) begin
        instr       <= imem_rdata;
        instr_valid <= 1'b1;
      end
      if (exec_fire) begin
        instr_valid <= 1'b0;
        pc_q        <= pc_d;
        if (ras_push && ras_full)  ras_overflow  <= 1'b1;
        if (ras_pop && ras_empty)  ras_underflow <= 1'b1;
        if (cmd_conflict(ret_en, call_en, jump_en, br_en)) cmd_error <= 1'b1;
      end
    end
  end

  assign pc = pc_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed vector bench for pc_fetch_unit
module tb_pc_fetch_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       imem_req;
  logic       imem_ack;
  logic [7:0] imem_rdata;
  logic [7:0] instr;
  logic       instr_valid;
  logic       exec_done;
  logic       br_en;
  logic       alu_zero;
  logic [7:0] br_offset;
  logic       jump_en;
  logic       call_en;
  logic       ret_en;
  logic [7:0] jump_target;
  logic [7:0] pc;
  logic       ras_overflow;
  logic       ras_underflow;
  logic       cmd_error;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] rdata;
    logic       br;
    logic       z;
    logic [7:0] off;
    logic       jmp;
    logic       call;
    logic       ret;
    logic [7:0] tgt;
    logic [7:0] exp_pc;
    logic       exp_ovf;
    logic       exp_unf;
    logic       exp_cmd;
  } vec_t;

  vec_t vecs[$];

  pc_fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .exec_done     (exec_done),
    .br_en         (br_en),
    .alu_zero      (alu_zero),
    .br_offset     (br_offset),
    .jump_en       (jump_en),
    .call_en       (call_en),
    .ret_en        (ret_en),
    .jump_target   (jump_target),
    .pc            (pc),
    .ras_overflow  (ras_overflow),
    .ras_underflow (ras_underflow),
    .cmd_error     (cmd_error)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [7:0] rdata, input logic br, input logic z,
                              input logic [7:0] off, input logic jmp, input logic call,
                              input logic ret, input logic [7:0] tgt, input logic [7:0] exp_pc,
                              input logic ovf, input logic unf, input logic cmd);
    vec_t v;
    v.rdata = rdata; v.br = br; v.z = z; v.off = off;
    v.jmp = jmp; v.call = call; v.ret = ret; v.tgt = tgt;
    v.exp_pc = exp_pc; v.exp_ovf = ovf; v.exp_unf = unf; v.exp_cmd = cmd;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic clear_cmds();
    exec_done = 0; br_en = 0; alu_zero = 0; br_offset = 8'h00;
    jump_en = 0; call_en = 0; ret_en = 0; jump_target = 8'h00;
  endtask

  task automatic wait_req(input string name);
    int t;
    t = 0;
    while (imem_req !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: imem_req never asserted within 50 cycles", name);
    end
  endtask

  task automatic do_fetch(input string name, input logic [7:0] rdata);
    wait_req(name);
    imem_ack = 1'b1;
    imem_rdata = rdata;
    @(negedge clk);
    imem_ack = 1'b0;
    imem_rdata = 8'h00;
    check({name, " instr"}, instr, rdata);
    check({name, " valid"}, {7'd0, instr_valid}, 8'h01);
    check({name, " req_low"}, {7'd0, imem_req}, 8'h00);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string name;
    name = $sformatf("vec%0d", idx);
    do_fetch(name, v.rdata);
    exec_done = 1; br_en = v.br; alu_zero = v.z; br_offset = v.off;
    jump_en = v.jmp; call_en = v.call; ret_en = v.ret; jump_target = v.tgt;
    @(negedge clk);
    clear_cmds();
    check({name, " pc"}, pc, v.exp_pc);
    check({name, " req"}, {7'd0, imem_req}, 8'h01);
    check({name, " valid_low"}, {7'd0, instr_valid}, 8'h00);
    check({name, " flags"}, {5'd0, ras_overflow, ras_underflow, cmd_error},
          {5'd0, v.exp_ovf, v.exp_unf, v.exp_cmd});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    imem_ack = 1'b0;
    imem_rdata = 8'h00;
    clear_cmds();

    //              rdata br z  off    jmp call ret tgt    exp_pc ovf unf cmd
    vecs.push_back(mk(8'h5A, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h01, 0, 0, 0));
    vecs.push_back(mk(8'h11, 0, 0, 8'h00, 1, 0, 0, 8'h10, 8'h10, 0, 0, 0));
    vecs.push_back(mk(8'h22, 1, 1, 8'hFE, 0, 0, 0, 8'h00, 8'h0F, 0, 0, 0));
    vecs.push_back(mk(8'h33, 0, 0, 8'h00, 1, 0, 0, 8'h10, 8'h10, 0, 0, 0));
    vecs.push_back(mk(8'h44, 1, 0, 8'hFE, 0, 0, 0, 8'h00, 8'h11, 0, 0, 0));
    vecs.push_back(mk(8'h55, 0, 0, 8'h00, 1, 0, 0, 8'hFF, 8'hFF, 0, 0, 0));
    vecs.push_back(mk(8'h66, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0));
    vecs.push_back(mk(8'h77, 0, 0, 8'h00, 1, 0, 0, 8'hF0, 8'hF0, 0, 0, 0));
    vecs.push_back(mk(8'h88, 1, 1, 8'h7F, 0, 0, 0, 8'h00, 8'h70, 0, 0, 0));
    vecs.push_back(mk(8'h99, 0, 0, 8'h00, 1, 0, 0, 8'h20, 8'h20, 0, 0, 0));
    vecs.push_back(mk(8'hA0, 0, 0, 8'h00, 0, 1, 0, 8'h30, 8'h30, 0, 0, 0));
    vecs.push_back(mk(8'hA1, 0, 0, 8'h00, 0, 1, 0, 8'h40, 8'h40, 0, 0, 0));
    vecs.push_back(mk(8'hA2, 0, 0, 8'h00, 0, 1, 0, 8'h50, 8'h50, 0, 0, 0));
    vecs.push_back(mk(8'hA3, 0, 0, 8'h00, 0, 1, 0, 8'h60, 8'h60, 0, 0, 0));
    vecs.push_back(mk(8'hA4, 0, 0, 8'h00, 0, 1, 0, 8'h70, 8'h70, 1, 0, 0));
    vecs.push_back(mk(8'hB0, 0, 0, 8'h00, 0, 0, 1, 8'h00, 8'h61, 1, 0, 0));
    vecs.push_back(mk(8'hB1, 0, 0, 8'h00, 0, 0, 1, 8'h00, 8'h51, 1, 0, 0));
    vecs.push_back(mk(8'hB2, 0, 0, 8'h00, 0, 0, 1, 8'h00, 8'h41, 1, 0, 0));
    vecs.push_back(mk(8'hB3, 0, 0, 8'h00, 0, 0, 1, 8'h00, 8'h31, 1, 0, 0));
    vecs.push_back(mk(8'hB4, 0, 0, 8'h00, 0, 0, 1, 8'h00, 8'h32, 1, 1, 0));
    vecs.push_back(mk(8'hC0, 0, 0, 8'h00, 1, 0, 1, 8'h99, 8'h33, 1, 1, 1));
    vecs.push_back(mk(8'hC1, 1, 1, 8'h80, 0, 0, 0, 8'h00, 8'hB4, 1, 1, 1));

    // Reset values while held in reset.
    repeat (2) @(negedge clk);
    check("rst pc", pc, 8'h00);
    check("rst instr", instr, 8'h00);
    check("rst ctrl", {5'd0, imem_req, instr_valid, 1'b0}, 8'h00);
    check("rst flags", {5'd0, ras_overflow, ras_underflow, cmd_error}, 8'h00);

    // First request rises on the first edge after release; ack lands at cycle 3.
    rst_n = 1'b1;
    @(negedge clk);
    check("req after release", {7'd0, imem_req}, 8'h01);
    @(negedge clk);
    check("fetch pc", pc, 8'h00);

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Ack during EXEC is ignored, then reset asynchronously mid-exec.
    do_fetch("exec_ack", 8'hC3);
    imem_ack = 1'b1;
    imem_rdata = 8'h3C;
    @(negedge clk);
    imem_ack = 1'b0;
    check("exec_ack instr held", instr, 8'hC3);
    check("exec_ack valid held", {7'd0, instr_valid}, 8'h01);
    exec_done = 1'b1;
    jump_en = 1'b1;
    jump_target = 8'h77;
    #1 rst_n = 1'b0;
    #1;
    check("async pc", pc, 8'h00);
    check("async instr", instr, 8'h00);
    check("async ctrl", {6'd0, imem_req, instr_valid}, 8'h00);
    check("async flags", {5'd0, ras_overflow, ras_underflow, cmd_error}, 8'h00);
    @(negedge clk);
    clear_cmds();
    rst_n = 1'b1;
    wait_req("post_rst");
    check("post_rst pc", pc, 8'h00);
    check("post_rst valid", {7'd0, instr_valid}, 8'h00);
    run_vec(99, mk(8'hD0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h01, 0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
